// File: rtl/weight_loader.sv
// weight_loader: streams one weight tile from the weight memory into the
// systolic array. After a start pulse it reads ROWS rows of four weights.
// Row addresses step by STRIDE words from a captured base address. Each
// fetched row is registered and presented with load_en and a row index.
//
// Build option: define WEIGHT_LOADER_REVERSE_EN to fetch rows last-first.
// The bottom array row is then loaded first. Cycle timing is unchanged.
module weight_loader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int STRIDE = 4,
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_w1,
    input  logic [DATA_W-1:0] mem_w2,
    input  logic [DATA_W-1:0] mem_w3,
    input  logic [DATA_W-1:0] mem_w4,
    output logic [DATA_W-1:0] w_out1,
    output logic [DATA_W-1:0] w_out2,
    output logic [DATA_W-1:0] w_out3,
    output logic [DATA_W-1:0] w_out4,
    output logic              load_en,
    output logic [IDX_W-1:0]  row_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  cnt;
    logic [IDX_W-1:0]  fetch_idx;
    logic [ADDR_W-1:0] base_q;
    logic              accept;
    logic              fetch_go;
    logic              fetch_last;

    // Map the row counter onto the memory row actually being fetched
    always_comb begin
`ifdef WEIGHT_LOADER_REVERSE_EN
        fetch_idx = LAST_IDX - cnt;
`else
        fetch_idx = cnt;
`endif
    end

    // Qualify start, unstalled fetch cycles, and the final row of the tile
    always_comb begin
        accept     = (state == IDLE) && start;
        fetch_go   = (state == FETCH) && !stall;
        fetch_last = fetch_go && (cnt == LAST_IDX);
    end

    // Next-state logic: leave IDLE on start, return after the last row
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = FETCH;
            FETCH:   if (fetch_last) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Memory address comes straight from registers; the sum wraps at 2^ADDR_W
    always_comb begin
        mem_addr = '0;
        if (state == FETCH)
            mem_addr = base_q + ADDR_W'(fetch_idx) * ADDR_W'(STRIDE);
    end

    // Capture the tile base on start and advance the row counter per fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                base_q <= base_addr;
                cnt    <= '0;
            end else if (fetch_go) begin
                cnt <= cnt + IDX_W'(1);
            end
        end
    end

    // Register the fetched row toward the array; data holds while not loading
    always_ff @(posedge clk) begin
        if (reset) begin
            w_out1  <= '0;
            w_out2  <= '0;
            w_out3  <= '0;
            w_out4  <= '0;
            row_idx <= '0;
            load_en <= 1'b0;
            done    <= 1'b0;
        end else begin
            load_en <= fetch_go;
            done    <= fetch_last;
            if (fetch_go) begin
                w_out1  <= mem_w1;
                w_out2  <= mem_w2;
                w_out3  <= mem_w3;
                w_out4  <= mem_w4;
                row_idx <= fetch_idx;
            end
        end
    end

    // Busy covers the fetch phase plus the cycle carrying the final row
    always_comb begin
        busy = (state == FETCH) || done;
    end

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: randomized self-checking bench for weight_loader.
// A timeline model builds the expected per-cycle outputs of each tile from
// the base address, stall pattern and memory contents. It then compares
// them with the DUT. The model follows WEIGHT_LOADER_REVERSE_EN when defined.
module tb_weight_loader;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int ROWS   = 4;
    localparam int STRIDE = 4;
    localparam int IDX_W  = 2;
    localparam int MEM_SZ = 1 << ADDR_W;
    localparam int VW     = ADDR_W + 3 + IDX_W + 4 * DATA_W;
    localparam int NC     = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stall;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_w1, mem_w2, mem_w3, mem_w4;
    logic [DATA_W-1:0] w_out1, w_out2, w_out3, w_out4;
    logic              load_en;
    logic [IDX_W-1:0]  row_idx;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [MEM_SZ];
    logic [ADDR_W-1:0] a1, a2, a3;
    logic [VW-1:0]     obs;

    int checks   = 0;
    int failures = 0;

    int                exp_addr [NC];
    bit                exp_le   [NC];
    bit                exp_done [NC];
    bit                exp_busy [NC];
    int                exp_row  [NC];
    logic [DATA_W-1:0] exp_w    [NC][4];
    bit                stall_pat[NC];
    int                last_cycle;
    logic [DATA_W-1:0] hold_w   [4];
    int                hold_row;

    weight_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .ROWS  (ROWS),
        .STRIDE(STRIDE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .stall    (stall),
        .mem_addr (mem_addr),
        .mem_w1   (mem_w1),
        .mem_w2   (mem_w2),
        .mem_w3   (mem_w3),
        .mem_w4   (mem_w4),
        .w_out1   (w_out1),
        .w_out2   (w_out2),
        .w_out3   (w_out3),
        .w_out4   (w_out4),
        .load_en  (load_en),
        .row_idx  (row_idx),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Combinational four-word memory read port, wrapping at the top
    assign a1     = mem_addr + ADDR_W'(1);
    assign a2     = mem_addr + ADDR_W'(2);
    assign a3     = mem_addr + ADDR_W'(3);
    assign mem_w1 = mem[mem_addr];
    assign mem_w2 = mem[a1];
    assign mem_w3 = mem[a2];
    assign mem_w4 = mem[a3];

    assign obs = {mem_addr, load_en, done, busy, row_idx, w_out1, w_out2, w_out3, w_out4};

    // Absolute safety net so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    // Memory row fetched for the k-th row of a tile
    function automatic int fidx(input int k);
`ifdef WEIGHT_LOADER_REVERSE_EN
        return ROWS - 1 - k;
`else
        return k;
`endif
    endfunction

    function automatic logic [VW-1:0] exp_vec(input int c);
        return {ADDR_W'(exp_addr[c]), exp_le[c], exp_done[c], exp_busy[c],
                IDX_W'(exp_row[c]), exp_w[c][0], exp_w[c][1], exp_w[c][2], exp_w[c][3]};
    endfunction

    // Build expected outputs for ntiles tiles started back-to-back from cycle 0
    task automatic build_timeline(input int base, input int ntiles);
        int c = 0;
        int k;
        logic [DATA_W-1:0] cur_w [4];
        int cur_row;
        for (int i = 0; i < NC; i++) begin
            exp_addr[i] = 0;
            exp_le[i]   = 0;
            exp_done[i] = 0;
            exp_busy[i] = 0;
            exp_row[i]  = 0;
            for (int j = 0; j < 4; j++) exp_w[i][j] = '0;
        end
        for (int t = 0; t < ntiles; t++) begin
            k = 0;
            while (k < ROWS && c < NC - 3) begin
                c++;
                exp_addr[c] = (base + fidx(k) * STRIDE) % MEM_SZ;
                exp_busy[c] = 1;
                if (!stall_pat[c]) begin
                    exp_le[c+1]  = 1;
                    exp_row[c+1] = fidx(k);
                    for (int j = 0; j < 4; j++) exp_w[c+1][j] = mem[(exp_addr[c] + j) % MEM_SZ];
                    k++;
                    if (k == ROWS) begin
                        exp_done[c+1] = 1;
                        exp_busy[c+1] = 1;
                    end
                end
            end
            c++;
        end
        last_cycle = c;
        cur_w   = hold_w;
        cur_row = hold_row;
        for (int i = 0; i < NC; i++) begin
            if (exp_le[i]) begin
                cur_row = exp_row[i];
                for (int j = 0; j < 4; j++) cur_w[j] = exp_w[i][j];
            end else begin
                exp_row[i] = cur_row;
                for (int j = 0; j < 4; j++) exp_w[i][j] = cur_w[j];
            end
        end
        hold_w   = cur_w;
        hold_row = cur_row;
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < NC; i++) stall_pat[i] = 0;
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        base_addr = '0;
        for (int c = 0; c < 2; c++) begin
            applyStimulus();
            @(negedge clk);
            checks++;
            if (obs !== '0) begin
                failures++;
                $display("[TB] FAIL reset cycle %0d: got %h expected %h", c, obs, {VW{1'b0}});
            end
        end
        applyStimulus();
        reset = 1'b0;
        hold_row = 0;
        for (int j = 0; j < 4; j++) hold_w[j] = '0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) mem[i] = DATA_W'(i);
        clear_stalls();
        build_timeline(0, 1);
        for (int c = 0; c <= last_cycle + 1; c++) begin
            applyStimulus();
            start = (c == 0);
            base_addr = '0;
            stall = stall_pat[c];
            @(negedge clk);
            checks++;
            if (obs !== exp_vec(c)) begin
                failures++;
                $display("[TB] FAIL basic cycle %0d: got %h expected %h", c, obs, exp_vec(c));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_stall();
        clear_stalls();
        stall_pat[2] = 1;
        stall_pat[3] = 1;
        build_timeline(0, 1);
        for (int c = 0; c <= last_cycle + 1; c++) begin
            applyStimulus();
            start = (c == 0);
            base_addr = '0;
            stall = stall_pat[c];
            @(negedge clk);
            checks++;
            if (obs !== exp_vec(c)) begin
                failures++;
                $display("[TB] FAIL stall cycle %0d: got %h expected %h", c, obs, exp_vec(c));
            end
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_wrap();
        clear_stalls();
        build_timeline(8188, 1);
        for (int c = 0; c <= last_cycle + 1; c++) begin
            applyStimulus();
            start = (c == 0);
            base_addr = ADDR_W'(8188);
            stall = stall_pat[c];
            @(negedge clk);
            checks++;
            if (obs !== exp_vec(c)) begin
                failures++;
                $display("[TB] FAIL wrap cycle %0d: got %h expected %h", c, obs, exp_vec(c));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base = $urandom_range(0, MEM_SZ - 1);
        clear_stalls();
        build_timeline(base, 1);
        for (int c = 0; c <= 3; c++) begin
            applyStimulus();
            start = (c == 0);
            base_addr = ADDR_W'(base);
            reset = (c == 3);
            @(negedge clk);
            checks++;
            if (obs !== exp_vec(c)) begin
                failures++;
                $display("[TB] FAIL reset_mid_pre cycle %0d: got %h expected %h", c, obs, exp_vec(c));
            end
        end
        hold_row = 0;
        for (int j = 0; j < 4; j++) hold_w[j] = '0;
        for (int c = 4; c <= 8; c++) begin
            applyStimulus();
            reset = 1'b0;
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (obs !== '0) begin
                failures++;
                $display("[TB] FAIL reset_mid_after cycle %0d: got %h expected %h", c, obs, {VW{1'b0}});
            end
        end
        base = $urandom_range(0, MEM_SZ - 1);
        build_timeline(base, 1);
        for (int c = 0; c <= last_cycle + 1; c++) begin
            applyStimulus();
            start = (c == 0);
            base_addr = ADDR_W'(base);
            @(negedge clk);
            checks++;
            if (obs !== exp_vec(c)) begin
                failures++;
                $display("[TB] FAIL reset_mid_reload cycle %0d: got %h expected %h", c, obs, exp_vec(c));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base = $urandom_range(0, MEM_SZ - 1);
        clear_stalls();
        build_timeline(base, 2);
        for (int c = 0; c <= last_cycle + 1; c++) begin
            applyStimulus();
            start = (c < last_cycle);
            base_addr = ADDR_W'(base);
            @(negedge clk);
            checks++;
            if (obs !== exp_vec(c)) begin
                failures++;
                $display("[TB] FAIL back_to_back cycle %0d: got %h expected %h", c, obs, exp_vec(c));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_random();
        int base;
        for (int t = 0; t < 6; t++) begin
            base = $urandom_range(0, MEM_SZ - 1);
            clear_stalls();
            for (int i = 1; i < 30; i++) stall_pat[i] = ($urandom_range(0, 2) == 0);
            build_timeline(base, 1);
            for (int c = 0; c <= last_cycle + 1; c++) begin
                applyStimulus();
                start = (c == 0) || (c > 1 && c < last_cycle && $urandom_range(0, 1) == 1);
                base_addr = (c == 0) ? ADDR_W'(base) : ADDR_W'($urandom_range(0, MEM_SZ - 1));
                stall = stall_pat[c];
                @(negedge clk);
                checks++;
                if (obs !== exp_vec(c)) begin
                    failures++;
                    $display("[TB] FAIL random tile %0d cycle %0d: got %h expected %h", t, c, obs, exp_vec(c));
                end
            end
            start = 1'b0;
            stall = 1'b0;
        end
    endtask

    // Test sequence
    initial begin
        for (int i = 0; i < MEM_SZ; i++) mem[i] = DATA_W'($urandom);
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
# weight_loader

Sequencer that streams one weight tile from the weight memory into the systolic array. On a `start` pulse it walks the memory in ROWS row reads of four weights each, at a stride of STRIDE words from a base address. Each fetched row is registered and presented to the array with a `load_en` strobe and a row index. It sits between the control unit, which issues `start` and `base_addr` and waits for `done`, and the weight memory's combinational four-word read port.

## Interface
- ADDR_W, 13, memory address width
- DATA_W, 8, weight width
- ROWS, 4, rows per tile (≥1, power of two, ≤16)
- STRIDE, 4, address step between rows
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin tile load; sampled only in IDLE
- base_addr  in  ADDR_W  tile base; captured on accepted start
- stall  in  1  array not ready; freezes fetch progress
- mem_addr  out  ADDR_W  address to weight memory
- mem_w1..mem_w4  in  DATA_W  memory words at mem_addr+0..+3 (same-cycle)
- w_out1..w_out4  out  DATA_W  registered row weights to array
- load_en  out  1  w_out*/row_idx valid this cycle
- row_idx  out  $clog2(ROWS) (min 1)  array row being loaded
- busy  out  1  tile load in progress
- done  out  1  one-cycle pulse with final row

## Operation
- States: IDLE, FETCH.
- IDLE:
  - mem_addr = 0.
  - start=1 captures base_addr into base_q, clears cnt, and moves to FETCH.
- FETCH:
  - Fetch index f = cnt, or ROWS-1-cnt with the reverse option.
  - mem_addr = base_q + f*STRIDE, combinational from registers, truncated mod 2^ADDR_W (wraps 8191→0).
  - stall=0: at the edge, mem_w1..4 are captured into w_out1..4; row_idx<=f, load_en<=1, cnt++.
  - stall=1: cnt, mem_addr and w_out* hold; load_en<=0.
  - Last non-stalled cycle (cnt==ROWS-1): also done<=1, and the state returns to IDLE.
- load_en and done are registered. Each is 0 in any cycle not following a non-stalled FETCH cycle.
- w_out* and row_idx hold their last values when load_en=0.
- busy is high in FETCH and in the cycle done is high.
- start while not in IDLE is ignored; it is not queued.
- start in the same cycle done is high is accepted, because the state is already IDLE. Back-to-back tiles therefore have no gap cycle.
- reset (any state, including mid-tile) takes effect the next edge:
  - state=IDLE, cnt=0, base_q=0;
  - w_out*=0, row_idx=0, load_en=0, done=0, busy=0, mem_addr=0.
  - A partially loaded tile is abandoned; no done is issued.

## Timing
- start sampled in cycle 0. FETCH runs in cycles 1..ROWS, with no stall.
- load_en is high in cycles 2..ROWS+1. done and the last load_en occur in cycle ROWS+1.
- Latency from start to done is ROWS+1 cycles, plus one cycle per stalled FETCH cycle.
- Memory read is combinational: mem_w* must be valid in the same cycle mem_addr is driven.
- busy is high cycles 1..ROWS+1.

## Configuration
- WEIGHT_LOADER_REVERSE_EN defined: rows are fetched last-first, f = ROWS-1-cnt, so the bottom array row is loaded first for shift-down arrays. row_idx reports f.
- Not defined: rows are fetched in ascending order, f = cnt.
- Cycle counts, done timing and all other behaviour are identical in both builds.

## Test plan
- Basic tile: memory[i]=i, base_addr=0, start pulse, no stall.
  - mem_addr 0,4,8,12 in cycles 1–4.
  - load_en cycles 2–5 with rows (0,1,2,3), (4,5,6,7), (8,9,10,11), (12,13,14,15) and row_idx 0..3.
  - done in cycle 5 only.
- Stall: same tile with stall=1 in cycles 2–3.
  - mem_addr holds 4 for cycles 2–4.
  - load_en is low in cycles 3–4.
  - done in cycle 7; data identical.
- Wrap: base_addr=8188.
  - mem_addr 8188, 0, 4, 8.
  - busy high cycles 1–5.
- Reset mid-tile: reset in cycle 3.
  - From cycle 4: all outputs 0, no done.
  - A new start then loads the tile correctly.
- Back-to-back and ignore:
  - start held high continuously: second tile's mem_addr=base in cycle 6, done pulses in cycles 5 and 10.
  - start pulsed during FETCH: no effect.
- Reverse build (macro defined), basic tile:
  - mem_addr 12,8,4,0.
  - row_idx 3,2,1,0.
  - First load_en carries (12,13,14,15).
